qsys_lab_sram_burst: RTL

- Parametrised on-chip SRAM with an Avalon-MM pipelined, burst-capable slave interface.
- Next-generation replacement for the fixed 32-bit x 4096 single-port SRAM slave in the Qsys lab system.
- Adds generic width/depth, configurable read latency, readdatavalid/waitrequest handshakes, and incrementing read/write bursts.
- Memory is inferred (byte-enabled RAM); sits behind the interconnect as a bulk data store for the Nios/DMA masters.

---
 rtl/qsys_lab_sram_burst.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/qsys_lab_sram_burst.sv
// Byte-enabled on-chip SRAM with an Avalon-MM pipelined, burst-capable slave port.
// Incrementing read/write bursts, read latency of 1 or 2, and a clock enable that freezes the whole block.
module qsys_lab_sram_burst #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned BURST_W      = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [BURST_W-1:0]  burstcount,
  input  logic                clken,
  input  logic                reset_req,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [ADDR_W-1:0]   burst_addr;
  logic [ADDR_W-1:0]   burst_addr_d;
  logic [BURST_W-1:0]  remaining;
  logic [BURST_W-1:0]  remaining_d;
  logic [BURST_W-1:0]  beats;
  logic                en;
  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_addr;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;

  assign en          = clken & ~reset_req;
  assign waitrequest = ~en | (state == RD_BURST);
  assign beats       = (burstcount == '0) ? BURST_W'(1) : burstcount;

  // State and burst bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      burst_addr <= '0;
      remaining  <= '0;
    end else begin
      state      <= state_d;
      burst_addr <= burst_addr_d;
      remaining  <= remaining_d;
    end
  end

  // Command accept, burst sequencing and RAM port control
  always_comb begin
    state_d      = state;
    burst_addr_d = burst_addr;
    remaining_d  = remaining;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = burst_addr;
    if (en) begin
      case (state)
        IDLE: begin
          if (chipselect && (read || write)) begin
            ram_addr     = address;
            burst_addr_d = address + ADDR_W'(1);
            remaining_d  = beats - BURST_W'(1);
            // write has priority; a simultaneous read is dropped
            if (write) ram_we = 1'b1;
            else       ram_re = 1'b1;
            if (beats > BURST_W'(1)) state_d = write ? WR_BURST : RD_BURST;
          end
        end
        WR_BURST: begin
          if (chipselect && write) begin
            ram_we       = 1'b1;
            burst_addr_d = burst_addr + ADDR_W'(1);
            remaining_d  = remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) state_d = IDLE;
          end
        end
        RD_BURST: begin
          ram_re       = 1'b1;
          burst_addr_d = burst_addr + ADDR_W'(1);
          remaining_d  = remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte-enabled RAM array; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem[ram_addr][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // First read stage: old data is returned on a same-word read-during-write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (en) begin
      rd_valid <= ram_re;
      if (ram_re) rd_data <= mem[ram_addr];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              out_valid;
      logic [DATA_W-1:0] out_data;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (en) begin
          out_valid <= rd_valid;
          out_data  <= rd_data;
        end
      end

      assign readdatavalid = out_valid;
      assign readdata      = out_data;
    end else begin : g_lat1
      assign readdatavalid = rd_valid;
      assign readdata      = rd_data;
    end
  endgenerate

endmodule
